// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a five-stage datapath.
//   * Detects load-use hazards between ID and EX and freezes PC / IF/ID while
//     injecting bubbles into ID/EX for LOAD_STALL_CYCLES cycles.
//   * Resolves taken branches in MEM: selects the branch target and flushes
//     IF/ID, ID/EX and EX/MEM. A taken branch always wins over a stall.
//   * Keeps saturating counters of stall cycles and taken-branch flushes.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles per load-use hazard (1..3)
//   CNT_W              performance counter width
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   IDEX_MemRead, IDEX_Rt          load in EX and its destination register
//   IFID_Rs, IFID_Rt, IFID_UsesRt  source registers of the instruction in ID
//   EXMEM_Branch, EXMEM_Zero       branch in MEM and its latched zero flag
//   PCWrite, IFIDWrite             update enables for PC and IF/ID
//   IDEXBubble                     zero the ID/EX control bits
//   IFIDFlush, IDEXFlush, EXMEMFlush  per-register flushes
//   PCSrc                          select branch target for next PC
//   Stalled                        controller is in its STALL state
//   StallCount, FlushCount         saturating activity counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rt,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             EXMEM_Branch,
    input  logic             EXMEM_Zero,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             PCSrc,
    output logic             Stalled,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // The detection cycle is the first stall cycle and the STALL state exits
    // when rem hits zero, so STALL is loaded with (length - 2).
    localparam logic [1:0] REM_INIT =
        (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;

    state_t     state_reg, state_next;
    logic [1:0] rem_reg, rem_next;

    logic take;
    logic haz;

    assign take = EXMEM_Branch & EXMEM_Zero;
    assign haz  = IDEX_MemRead & (IDEX_Rt != 5'd0) &
                  ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            rem_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next state. haz is deliberately ignored in STALL: ID/EX already holds
    // a bubble after the first cycle, so only the counter sets the length.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        case (state_reg)
            RUN: begin
                if (!take && haz && (LOAD_STALL_CYCLES > 1)) begin
                    state_next = STALL;
                    rem_next   = REM_INIT;
                end
            end
            STALL: begin
                // A taken branch flushes the stalled (younger) instruction,
                // so the stall is abandoned.
                if (take || (rem_reg == 2'd0)) begin
                    state_next = RUN;
                end else begin
                    rem_next = rem_reg - 2'd1;
                end
            end
            default: begin
                state_next = RUN;
                rem_next   = 2'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Combinational controls. Reset is decoded here as well so the pipeline
    // is frozen for the whole time rst is high, not just after an edge.
    // ---------------------------------------------------------------------
    always_comb begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b0;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        PCSrc      = 1'b0;
        if (rst) begin
            IDEXBubble = 1'b1;
        end else if (take) begin
            PCSrc      = 1'b1;
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (((state_reg == RUN) && haz) || (state_reg == STALL)) begin
            IDEXBubble = 1'b1;
        end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
        end
    end

    // Async reset forces RUN immediately, so Stalled drops with rst.
    assign Stalled = (state_reg == STALL);

    // ---------------------------------------------------------------------
    // Saturating activity counters: [0] stall cycles, [1] taken branches.
    // ---------------------------------------------------------------------
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc[0] = IDEXBubble;
    assign cnt_inc[1] = take & ~rst;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign StallCount = cnt_reg[0];
    assign FlushCount = cnt_reg[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Three controller instances: LOAD_STALL_CYCLES=1 (d=0), LOAD_STALL_CYCLES=3
// (d=1) and LOAD_STALL_CYCLES=1 with 4-bit counters (d=2). Only the instance
// under test sees non-idle inputs. Expected control words and counter values
// are queued when a vector is driven and compared half a cycle later.
// Control word layout: {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush,
//                       IDEXFlush, EXMEMFlush, PCSrc, Stalled}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    typedef struct packed {
        logic       mr;
        logic [4:0] idex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       z;
    } in_t;

    typedef struct {
        in_t        v;
        logic [7:0] c;
        int         sc;
        int         fc;
    } vec_t;

    typedef struct {
        int         tag;
        int         d;
        logic [7:0] c;
        int         sc;
        int         fc;
    } exp_t;

    localparam logic [7:0] C_RUN   = 8'b1100_0000;
    localparam logic [7:0] C_BUB   = 8'b0010_0000;
    localparam logic [7:0] C_BUBS  = 8'b0010_0001;
    localparam logic [7:0] C_TAKE  = 8'b1101_1110;
    localparam logic [7:0] C_TAKES = 8'b1101_1111;
    localparam logic [7:0] C_RST   = 8'b0010_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  in_v [3];

    logic [7:0]  ctrl_a [3];
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;

    int errors = 0;
    int checks = 0;
    int tag    = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst(rst),
        .IDEX_MemRead(in_v[0].mr), .IDEX_Rt(in_v[0].idex_rt),
        .IFID_Rs(in_v[0].rs), .IFID_Rt(in_v[0].rt), .IFID_UsesRt(in_v[0].uses_rt),
        .EXMEM_Branch(in_v[0].br), .EXMEM_Zero(in_v[0].z),
        .PCWrite(ctrl_a[0][7]), .IFIDWrite(ctrl_a[0][6]), .IDEXBubble(ctrl_a[0][5]),
        .IFIDFlush(ctrl_a[0][4]), .IDEXFlush(ctrl_a[0][3]), .EXMEMFlush(ctrl_a[0][2]),
        .PCSrc(ctrl_a[0][1]), .Stalled(ctrl_a[0][0]),
        .StallCount(sc0), .FlushCount(fc0)
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst(rst),
        .IDEX_MemRead(in_v[1].mr), .IDEX_Rt(in_v[1].idex_rt),
        .IFID_Rs(in_v[1].rs), .IFID_Rt(in_v[1].rt), .IFID_UsesRt(in_v[1].uses_rt),
        .EXMEM_Branch(in_v[1].br), .EXMEM_Zero(in_v[1].z),
        .PCWrite(ctrl_a[1][7]), .IFIDWrite(ctrl_a[1][6]), .IDEXBubble(ctrl_a[1][5]),
        .IFIDFlush(ctrl_a[1][4]), .IDEXFlush(ctrl_a[1][3]), .EXMEMFlush(ctrl_a[1][2]),
        .PCSrc(ctrl_a[1][1]), .Stalled(ctrl_a[1][0]),
        .StallCount(sc1), .FlushCount(fc1)
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst),
        .IDEX_MemRead(in_v[2].mr), .IDEX_Rt(in_v[2].idex_rt),
        .IFID_Rs(in_v[2].rs), .IFID_Rt(in_v[2].rt), .IFID_UsesRt(in_v[2].uses_rt),
        .EXMEM_Branch(in_v[2].br), .EXMEM_Zero(in_v[2].z),
        .PCWrite(ctrl_a[2][7]), .IFIDWrite(ctrl_a[2][6]), .IDEXBubble(ctrl_a[2][5]),
        .IFIDFlush(ctrl_a[2][4]), .IDEXFlush(ctrl_a[2][3]), .EXMEMFlush(ctrl_a[2][2]),
        .PCSrc(ctrl_a[2][1]), .Stalled(ctrl_a[2][0]),
        .StallCount(sc2), .FlushCount(fc2)
    );

    function automatic in_t mk(logic mr, logic [4:0] irt, logic [4:0] rs,
                               logic [4:0] rt, logic u, logic br, logic z);
        in_t r;
        r.mr = mr; r.idex_rt = irt; r.rs = rs; r.rt = rt;
        r.uses_rt = u; r.br = br; r.z = z;
        return r;
    endfunction

    function automatic int act_sc(int d);
        case (d)
            0:       return int'(sc0);
            1:       return int'(sc1);
            default: return int'(sc2);
        endcase
    endfunction

    function automatic int act_fc(int d);
        case (d)
            0:       return int'(fc0);
            1:       return int'(fc1);
            default: return int'(fc2);
        endcase
    endfunction

    task automatic check(int t, int d, logic [7:0] ec, int esc, int efc);
        logic [7:0] ac;
        int asc, afc;
        ac  = ctrl_a[d];
        asc = act_sc(d);
        afc = act_fc(d);
        checks++;
        if (ac !== ec || asc != esc || afc != efc) begin
            errors++;
            $display("FAIL step%0d dut%0d: ctrl=%b stall=%0d flush=%0d, required ctrl=%b stall=%0d flush=%0d",
                     t, d, ac, asc, afc, ec, esc, efc);
        end else begin
            $display("ok   step%0d dut%0d: ctrl=%b stall=%0d flush=%0d", t, d, ac, asc, afc);
        end
    endtask

    // Called just after a rising edge: drive, queue expectation, compare at
    // the falling edge, then advance to just after the next rising edge.
    task automatic step(int d, in_t v, logic [7:0] ec, int esc, int efc);
        exp_t e;
        for (int k = 0; k < 3; k++) in_v[k] = '0;
        in_v[d] = v;
        tag++;
        sb_q.push_back('{tag, d, ec, esc, efc});
        @(negedge clk);
        e = sb_q.pop_front();
        check(e.tag, e.d, e.c, e.sc, e.fc);
        @(posedge clk);
        #1;
    endtask

    in_t  idle, hz, tk;
    vec_t tbl [14];

    initial begin
        idle = '0;
        hz   = mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        tk   = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);

        tbl[0]  = '{idle, C_RUN, 0, 0};
        tbl[1]  = '{hz, C_BUB, 0, 0};
        tbl[2]  = '{idle, C_RUN, 1, 0};
        tbl[3]  = '{mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), C_RUN, 1, 0};
        tbl[4]  = '{mk(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0), C_RUN, 1, 0};
        tbl[5]  = '{mk(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0), C_BUB, 1, 0};
        tbl[6]  = '{mk(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0), C_RUN, 2, 0};
        tbl[7]  = '{tk, C_TAKE, 2, 0};
        tbl[8]  = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0), C_RUN, 2, 1};
        tbl[9]  = '{mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1), C_TAKE, 2, 1};
        tbl[10] = '{idle, C_RUN, 2, 2};
        tbl[11] = '{hz, C_BUB, 2, 2};
        tbl[12] = '{hz, C_BUB, 3, 2};
        tbl[13] = '{idle, C_RUN, 4, 2};

        for (int k = 0; k < 3; k++) in_v[k] = '0;

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check(0, k, C_RST, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LOAD_STALL_CYCLES=1: table of single-cycle vectors
        for (int i = 0; i < 14; i++) step(0, tbl[i].v, tbl[i].c, tbl[i].sc, tbl[i].fc);

        // LOAD_STALL_CYCLES=3: basic three-cycle stall
        step(1, hz,   C_BUB,  0, 0);
        step(1, idle, C_BUBS, 1, 0);
        step(1, idle, C_BUBS, 2, 0);
        step(1, idle, C_RUN,  3, 0);
        // Hazard held throughout: ignored in STALL, restarts with no gap
        step(1, hz,   C_BUB,  3, 0);
        step(1, hz,   C_BUBS, 4, 0);
        step(1, hz,   C_BUBS, 5, 0);
        step(1, hz,   C_BUB,  6, 0);
        step(1, idle, C_BUBS, 7, 0);
        step(1, idle, C_BUBS, 8, 0);
        step(1, idle, C_RUN,  9, 0);
        // Taken branch in stall cycle 2 wins and ends the stall
        step(1, hz,   C_BUB,   9, 0);
        step(1, tk,   C_TAKES, 10, 0);
        step(1, idle, C_RUN,   10, 1);
        // Asynchronous reset in the middle of a stall
        step(1, hz,   C_BUB,  10, 1);
        step(1, idle, C_BUBS, 11, 1);
        rst = 1'b1;
        #1;
        check(100, 1, C_RST, 0, 0);
        check(101, 0, C_RST, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, idle, C_RUN, 0, 0);

        // CNT_W=4: 20 back-to-back stalls saturate at 15
        for (int i = 0; i < 20; i++) step(2, hz, C_BUB, (i < 15) ? i : 15, 0);
        step(2, idle, C_RUN, 15, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage datapath. It detects load-use hazards between the ID and EX stages and resolves taken branches in the MEM stage. It drives the PC write enable, the IF/ID write enable, the ID/EX bubble insert and the per-stage flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers. A small state machine stretches load-use stalls to a configurable length, and saturating counters record stall and flush activity for performance checks.

## Interface
- LOAD_STALL_CYCLES, default 1: bubbles inserted per load-use hazard; legal range 1..3.
- CNT_W, default 16: width of the performance counters.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_Rt  in  5  destination register of that load
- IFID_Rs  in  5  rs field of the instruction in ID
- IFID_Rt  in  5  rt field of the instruction in ID
- IFID_UsesRt  in  1  instruction in ID reads rt (R-type, store, branch)
- EXMEM_Branch  in  1  instruction in MEM is a branch
- EXMEM_Zero  in  1  ALU zero flag latched with that branch
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register update enable
- IDEXBubble  out  1  force all ID/EX control bits to 0
- IFIDFlush, IDEXFlush, EXMEMFlush  out  1 each  clear the control bits of that register on the next edge
- PCSrc  out  1  select branch target for the next PC
- Stalled  out  1  state is STALL
- StallCount  out  CNT_W  total stall cycles, saturating
- FlushCount  out  CNT_W  total taken-branch flushes, saturating

## Operation
- Taken branch: `take = EXMEM_Branch & EXMEM_Zero`.
- Hazard: `haz = IDEX_MemRead & (IDEX_Rt != 0) & ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)))`.
- States and counter:
  - States are RUN and STALL.
  - A 2-bit down-counter `rem` counts the remaining stall cycles.
- Outputs are combinational from state and inputs:
  - If `take`: PCSrc=1, PCWrite=1, IFIDWrite=1, IFIDFlush=IDEXFlush=EXMEMFlush=1, IDEXBubble=0. The branch has priority over any stall.
  - Else if (RUN & haz) or STALL: PCWrite=0, IFIDWrite=0, IDEXBubble=1, all flushes 0, PCSrc=0.
  - Otherwise: PCWrite=1, IFIDWrite=1, everything else 0.
- Transitions:
  - RUN, `take`: stay in RUN.
  - RUN, `haz` and LOAD_STALL_CYCLES>1: go to STALL, `rem` <= LOAD_STALL_CYCLES-2.
  - RUN, `haz` and LOAD_STALL_CYCLES=1: stay in RUN.
  - STALL, `take`: go to RUN. The stalled instruction is younger than the branch and is flushed, so the stall is abandoned.
  - STALL, `rem`=0: go to RUN.
  - STALL, otherwise: `rem` <= `rem`-1.
- `haz` is not re-evaluated in STALL. ID/EX holds a bubble after the first stall cycle, so the counter alone defines the stall length.
- Counters:
  - StallCount increments every cycle IDEXBubble=1.
  - FlushCount increments every cycle `take`=1.
  - Both saturate at all ones and never wrap.
- Reset, asynchronous, takes effect immediately:
  - State returns to RUN, `rem`=0, StallCount=0, FlushCount=0.
  - While rst=1: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=IDEXFlush=EXMEMFlush=0, PCSrc=0, Stalled=0.
  - A reset during STALL drops the stall. After release the controller is in RUN.

## Timing
- Detection to effect is 0 cycles; the controls are combinational. The pipeline registers sample them on the same rising edge.
- Total stall length per hazard is exactly LOAD_STALL_CYCLES cycles, counting the detection cycle. PC and IF/ID are frozen for that many edges.
- Branch penalty:
  - PCSrc, the three flushes and the FlushCount increment are asserted for exactly one cycle per taken branch.
  - The next PC is the target on the following edge.
- Stalled is a registered state decode. It is high in cycles 2..N of an N-cycle stall and low otherwise.
- Counters update on the edge that ends the qualifying cycle. They are readable one cycle later.
- Back-to-back hazards: a new `haz` in the first RUN cycle after a stall starts a fresh stall with no gap cycle.

## Test plan
- LOAD_STALL_CYCLES=1; load r5 in EX, ID reads rs=5 -> one cycle with PCWrite=0, IFIDWrite=0, IDEXBubble=1, Stalled stays 0, StallCount=1.
- LOAD_STALL_CYCLES=3; same hazard -> three consecutive bubble cycles, Stalled high in cycles 2–3, then RUN; StallCount=3.
- IDEX_Rt=0, or rt matches with IFID_UsesRt=0 -> no stall; PCWrite=1, StallCount unchanged.
- EXMEM_Branch=1, EXMEM_Zero=1 -> one cycle with PCSrc=1 and all three flushes=1; FlushCount=1. With Zero=0 -> no flush.
- LOAD_STALL_CYCLES=3; taken branch in stall cycle 2 -> branch outputs win, state back to RUN next edge, StallCount=1, FlushCount=1.
- rst pulsed mid-STALL; separately, CNT_W=4 with 20 stalls -> outputs take reset values immediately and counters clear; StallCount holds at 15.
